cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 170 +++++++++++++++++
 tb/tb_cache_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : Direct-mapped, one-word-per-line, write-through /
//                no-write-allocate cache between a pipeline memory stage and
//                an SRAM controller. Read hits complete with zero wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_controller #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 17 - IDX_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;

  // Line storage: only the valid bits need a reset value.
  logic               valid_q [LINES];
  logic [TAG_W-1:0]   tag_q   [LINES];
  logic [31:0]        data_q  [LINES];

  logic [IDX_W-1:0]   req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;
  logic               req_hit, lat_hit;
  logic               fill_en, upd_en;

  // Bit 0 selects the SRAM halfword, so the line index starts at bit 1.
  assign req_idx = mem_addr[IDX_W:1];
  assign req_tag = mem_addr[17:IDX_W+1];
  assign lat_idx = addr_q[IDX_W:1];
  assign lat_tag = addr_q[17:IDX_W+1];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // SRAM command outputs come straight from flops; addr/data hold the latched request.
  assign sram_rd_en = rd_en_q;
  assign sram_wr_en = wr_en_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  // Next-state, request latching and same-cycle pipeline handshake.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    mem_ready = 1'b1;
    mem_rdata = '0;
    fill_en   = 1'b0;
    upd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // Reads take priority when both requests are raised together.
        if (mem_rd_en) begin
          if (req_hit) begin
            mem_rdata = data_q[req_idx];
          end else begin
            mem_ready = 1'b0;
            addr_d    = mem_addr;
            rd_en_d   = 1'b1;
            state_d   = RD_ISSUE;
          end
        end else if (mem_wr_en) begin
          mem_ready = 1'b0;
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wr_en_d   = 1'b1;
          state_d   = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_ready = 1'b0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (sram_ready) begin
          mem_rdata = sram_rdata;
          rd_en_d   = 1'b0;
          fill_en   = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_ready = 1'b0;
        end
      end
      WR_ISSUE: begin
        mem_ready = 1'b0;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        if (sram_ready) begin
          wr_en_d = 1'b0;
          upd_en  = lat_hit;  // write-through: refresh a resident line only
          state_d = IDLE;
        end else begin
          mem_ready = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
    // Present an idle, ready interface while reset is held.
    if (!rst_n) begin
      mem_ready = 1'b1;
      mem_rdata = '0;
    end
  end

  // State, latched request and line array updates; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      if (fill_en) begin
        valid_q[lat_idx] <= 1'b1;
        tag_q[lat_idx]   <= lat_tag;
        data_q[lat_idx]  <= sram_rdata;
      end
      if (upd_en) begin
        data_q[lat_idx] <= wdata_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cache_controller
//  Description : Bench for cache_controller: a reference cache/memory model
//                predicts each response, a monitor compares DUT completions,
//                and a responder models the SRAM controller handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

  localparam int LINES = 64;
  localparam int IDXW  = $clog2(LINES);
  localparam int TAGW  = 17 - IDXW;

  logic        clk;
  logic        rst_n;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_ready;

  cache_controller #(.LINES(LINES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        rd;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] data;
    bit        fast;   // read hit: zero wait states, no SRAM traffic
    int        lat;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] ref_mem  [bit [31:0]];
  bit [31:0] sram_mem [bit [31:0]];
  bit            rv   [LINES];
  bit [TAGW-1:0] rt   [LINES];
  bit [31:0]     rdat [LINES];

  function automatic bit [31:0] dflt(input bit [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic bit [31:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic bit [31:0] sram_rd(input bit [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < LINES; i++) rv[i] = 1'b0;
  endtask

  // ---------------- SRAM controller responder ----------------
  int lat_cfg     = 1;
  int n_rd_cmd    = 0;
  int n_wr_cmd    = 0;
  bit allow_orphan = 1'b0;

  initial begin : sram_model
    int        ph;
    int        cnt;
    bit        s_rst, s_rd, s_wr, c_wr;
    bit [31:0] s_a, s_wd, c_a;
    exp_t      e;
    ph = 0; cnt = 0; c_wr = 1'b0; c_a = '0;
    sram_ready = 1'b1;
    sram_rdata = '0;
    forever begin
      @(negedge clk);
      s_rst = rst_n; s_rd = sram_rd_en; s_wr = sram_wr_en;
      s_a = sram_addr; s_wd = sram_wdata;
      @(posedge clk);
      #1;
      if (!s_rst) begin
        ph = 0; sram_ready = 1'b1; sram_rdata = '0;
      end else begin
        case (ph)
          0: if (s_rd || s_wr) begin
            ph = 1; cnt = lat_cfg; sram_ready = 1'b0;
            c_a = s_a; c_wr = s_wr;
            if (s_wr) begin sram_mem[s_a] = s_wd; n_wr_cmd++; end
            else n_rd_cmd++;
            if (exp_q.size() == 0) begin
              if (!allow_orphan) chk("unexpected_cmd", 32'(s_a), 32'hFFFFFFFF);
            end else begin
              e = exp_q[0];
              chk("cmd_kind", 32'(s_wr), 32'(!e.rd));
              chk("cmd_addr", s_a, e.addr);
              if (s_wr) chk("cmd_wdata", s_wd, e.wdata);
            end
          end
          1: if (cnt <= 1) begin
            ph = 2; sram_ready = 1'b1;
            sram_rdata = c_wr ? 32'h0 : sram_rd(c_a);
          end else cnt--;
          default: begin ph = 0; sram_rdata = '0; end
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int   wait_cnt;
    int   en_cnt;
    exp_t e;
    wait_cnt = 0; en_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wait_cnt = 0; en_cnt = 0; n_rd_cmd = 0; n_wr_cmd = 0;
      end else begin
        chk("enables_exclusive", 32'(sram_rd_en & sram_wr_en), 32'h0);
        if (mem_rd_en || mem_wr_en) begin
          if (sram_rd_en || sram_wr_en) en_cnt++;
          if (!mem_ready) begin
            wait_cnt++;
            chk("rdata_zero_busy", mem_rdata, 32'h0);
          end else if (exp_q.size() == 0) begin
            chk("unexpected_completion", mem_rdata, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            if (e.rd) chk("rd_data", mem_rdata, e.data);
            else      chk("wr_rdata_zero", mem_rdata, 32'h0);
            chk("wait_cycles", 32'(wait_cnt), 32'(e.fast ? 0 : e.lat + 2));
            chk("en_cycles",   32'(en_cnt),   32'(e.fast ? 0 : e.lat + 2));
            chk("sram_rd_cmds", 32'(n_rd_cmd), 32'((e.rd && !e.fast) ? 1 : 0));
            chk("sram_wr_cmds", 32'(n_wr_cmd), 32'(e.rd ? 0 : 1));
            wait_cnt = 0; en_cnt = 0; n_rd_cmd = 0; n_wr_cmd = 0;
          end
        end else begin
          chk("idle_ready", 32'(mem_ready), 32'h1);
          chk("idle_rdata", mem_rdata, 32'h0);
          chk("idle_enables", 32'({sram_rd_en, sram_wr_en}), 32'h0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit rd, input bit wr, input bit [31:0] a,
                        input bit [31:0] wd, input int lat);
    exp_t          e;
    int            idx;
    bit [TAGW-1:0] tag;
    bit            done;
    idx = int'((a >> 1) % LINES);
    tag = TAGW'(a >> (IDXW + 1));
    e.rd = rd; e.addr = a; e.wdata = wd; e.lat = lat; e.data = '0; e.fast = 1'b0;
    if (rd) begin
      if (rv[idx] && rt[idx] == tag) begin
        e.fast = 1'b1; e.data = rdat[idx];
      end else begin
        e.data = ref_rd(a);
        rv[idx] = 1'b1; rt[idx] = tag; rdat[idx] = e.data;
      end
    end else begin
      ref_mem[a] = wd;
      if (rv[idx] && rt[idx] == tag) rdat[idx] = wd;
    end
    exp_q.push_back(e);
    lat_cfg = lat;
    mem_rd_en = rd; mem_wr_en = wr; mem_addr = a; mem_wdata = wd;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (mem_ready) done = 1'b1;
      else begin
        // Once latched, the request inputs must no longer matter.
        @(posedge clk); #1;
        mem_addr = $urandom; mem_wdata = $urandom;
      end
    end
    if (!done) begin
      chk("timeout", 32'(done), 32'h1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit [31:0] a;
    int        kind;
    rst_n = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    ref_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_rd_en", 32'(sram_rd_en), 32'h0);
    chk("rst_sram_wr_en", 32'(sram_wr_en), 32'h0);
    chk("rst_sram_addr",  sram_addr,  32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    chk("rst_mem_rdata",  mem_rdata,  32'h0);
    chk("rst_mem_ready",  32'(mem_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    ref_mem[32'h10]  = 32'hDEADBEEF;
    sram_mem[32'h10] = 32'hDEADBEEF;
    do_req(1, 0, 32'h10, 0, 6);             // cold miss, 6-cycle SRAM
    do_req(1, 0, 32'h10, 0, 3);             // zero-wait hit
    do_req(0, 1, 32'h10, 32'h12345678, 2);  // write-through to resident line
    do_req(1, 0, 32'h10, 0, 2);
    do_req(0, 1, 32'h90, 32'hCAFEF00D, 2);  // same index, other tag: no allocate
    do_req(1, 0, 32'h10, 0, 2);
    do_req(1, 0, 32'h90, 0, 2);             // conflict miss replaces line 8
    do_req(1, 0, 32'h10, 0, 2);
    do_req(1, 1, 32'h7E, 32'h0BADF00D, 1);  // both requests: read, last index
    do_req(1, 0, 32'h7E, 0, 1);

    // Reset in the middle of a read miss of 0x20.
    allow_orphan = 1'b1;
    lat_cfg = 6;
    mem_rd_en = 1'b1; mem_addr = 32'h20;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sram_rd_en", 32'(sram_rd_en), 32'h0);
    chk("abort_mem_ready",  32'(mem_ready), 32'h1);
    chk("abort_sram_addr",  sram_addr, 32'h0);
    ref_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    allow_orphan = 1'b0;
    do_req(1, 0, 32'h20, 0, 2);             // must miss after reset
    do_req(1, 0, 32'h10, 0, 1);             // previously resident: misses too

    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 2)) << (IDXW + 1)) | (32'($urandom_range(0, 3)) << 1);
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 16383)) << 18);
      kind = $urandom_range(0, 7);
      if (kind <= 3 || kind == 7) do_req(1, 0, a, $urandom, $urandom_range(1, 5));
      else if (kind <= 5)         do_req(0, 1, a, $urandom, $urandom_range(1, 5));
      else                        do_req(1, 1, a, $urandom, $urandom_range(1, 5));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
